// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
//   Instruction fetch stage of the RV32I core. Owns the program counter,
//   fetches one word at a time from instruction memory over a req/valid
//   handshake, holds the word in an instruction register and exposes the
//   decode fields the controller needs. The next PC is chosen at retire
//   time from PC+4 or a controller-supplied target.
//
// Parameters
//   RESET_PC       PC loaded on reset (word aligned)
//   NOP            instruction register value after reset (addi x0,x0,0)
//   RESET_INSTRET  retired-instruction counter value after reset
//
// Ports
//   clock        in   1   system clock, rising edge
//   reset        in   1   asynchronous active-high reset
//   stall        in   1   core not ready to retire the held instruction
//   PC_select    in   1   next PC is PC_target (1) or PC+4 (0), used at retire
//   PC_target    in  32   branch/jump target
//   imem_req     out  1   fetch request, held until imem_valid
//   imem_addr    out 32   fetch address (= PC)
//   imem_valid   in   1   imem_rdata valid this cycle
//   imem_rdata   in  32   fetched instruction word
//   instr        out 32   instruction register
//   instr_valid  out  1   instr holds a fetched, unretired instruction
//   opcode       out  7   instr[6:0]
//   funct3       out  3   instr[14:12]
//   funct7b5     out  1   instr[30]
//   PC           out 32   address of instr
//   PC_plus4     out 32   PC + 4, modulo 2^32
//   instret      out 32   retired-instruction counter
//   fault        out  1   sticky: misaligned target was taken
// ---------------------------------------------------------------------------
module fetch_unit #(
  parameter logic [31:0] RESET_PC      = 32'h0000_0000,
  parameter logic [31:0] NOP           = 32'h0000_0013,
  parameter logic [31:0] RESET_INSTRET = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        stall,
  input  logic        PC_select,
  input  logic [31:0] PC_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_valid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [6:0]  opcode,
  output logic [2:0]  funct3,
  output logic        funct7b5,
  output logic [31:0] PC,
  output logic [31:0] PC_plus4,
  output logic [31:0] instret,
  output logic        fault
);

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_FETCH = 2'b01;
  localparam logic [1:0] ST_READY = 2'b10;
  localparam logic [1:0] ST_FAULT = 2'b11;

  // A jump target is only legal when it lands on a word boundary.
  function automatic logic is_misaligned(input logic [31:0] addr);
    return (addr[1:0] != 2'b00);
  endfunction

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] instret_q, instret_d;
  logic        fault_q, fault_d;
  logic        imem_req_q, imem_req_d;
  logic        instr_valid_q, instr_valid_d;
  logic [31:0] pc_plus4_s;

  assign pc_plus4_s = pc_q + 32'd4;

  // Next-state and datapath update for the fetch FSM.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    instret_d = instret_q;
    fault_d   = fault_q;
    case (state_q)
      ST_IDLE: begin
        state_d = ST_FETCH;
      end
      ST_FETCH: begin
        if (imem_valid) begin
          instr_d = imem_rdata;
          state_d = ST_READY;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_READY: begin
        if (stall) begin
          state_d = ST_READY;
        end else if (PC_select && is_misaligned(PC_target)) begin
          // Taking a misaligned target is fatal: PC and instret stay put.
          fault_d = 1'b1;
          state_d = ST_FAULT;
        end else begin
          pc_d      = PC_select ? PC_target : pc_plus4_s;
          instret_d = instret_q + 32'd1;
          state_d   = ST_FETCH;
        end
      end
      ST_FAULT: begin
        state_d = ST_FAULT;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Handshake outputs are registered, so derive them from the next state.
  always_comb begin
    imem_req_d    = (state_d == ST_FETCH);
    instr_valid_d = (state_d == ST_READY);
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      pc_q          <= RESET_PC;
      instr_q       <= NOP;
      instret_q     <= RESET_INSTRET;
      fault_q       <= 1'b0;
      imem_req_q    <= 1'b0;
      instr_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      instret_q     <= instret_d;
      fault_q       <= fault_d;
      imem_req_q    <= imem_req_d;
      instr_valid_q <= instr_valid_d;
    end
  end

  assign imem_req    = imem_req_q;
  assign imem_addr   = pc_q;
  assign instr       = instr_q;
  assign instr_valid = instr_valid_q;
  assign opcode      = instr_q[6:0];
  assign funct3      = instr_q[14:12];
  assign funct7b5    = instr_q[30];
  assign PC          = pc_q;
  assign PC_plus4    = pc_plus4_s;
  assign instret     = instret_q;
  assign fault       = fault_q;

endmodule

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit
//   Directed bench for fetch_unit. A second instance preset near the top of
//   the address space and counter range exercises the wrap cases.
// ---------------------------------------------------------------------------
module tb_fetch_unit;

  logic        clock;
  logic        reset;
  logic        stall;
  logic        PC_select;
  logic [31:0] PC_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_valid;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        funct7b5;
  logic [31:0] PC;
  logic [31:0] PC_plus4;
  logic [31:0] instret;
  logic        fault;

  logic        b_reset;
  logic        b_stall;
  logic        b_PC_select;
  logic [31:0] b_PC_target;
  logic        b_imem_req;
  logic [31:0] b_imem_addr;
  logic        b_imem_valid;
  logic [31:0] b_imem_rdata;
  logic [31:0] b_instr;
  logic        b_instr_valid;
  logic [6:0]  b_opcode;
  logic [2:0]  b_funct3;
  logic        b_funct7b5;
  logic [31:0] b_PC;
  logic [31:0] b_PC_plus4;
  logic [31:0] b_instret;
  logic        b_fault;

  int compared;
  int mismatched;

  fetch_unit dut (
    .clock(clock), .reset(reset), .stall(stall),
    .PC_select(PC_select), .PC_target(PC_target),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_valid(imem_valid), .imem_rdata(imem_rdata),
    .instr(instr), .instr_valid(instr_valid),
    .opcode(opcode), .funct3(funct3), .funct7b5(funct7b5),
    .PC(PC), .PC_plus4(PC_plus4), .instret(instret), .fault(fault)
  );

  fetch_unit #(
    .RESET_PC(32'hFFFF_FFFC),
    .NOP(32'h0000_0013),
    .RESET_INSTRET(32'hFFFF_FFFF)
  ) dut_wrap (
    .clock(clock), .reset(b_reset), .stall(b_stall),
    .PC_select(b_PC_select), .PC_target(b_PC_target),
    .imem_req(b_imem_req), .imem_addr(b_imem_addr),
    .imem_valid(b_imem_valid), .imem_rdata(b_imem_rdata),
    .instr(b_instr), .instr_valid(b_instr_valid),
    .opcode(b_opcode), .funct3(b_funct3), .funct7b5(b_funct7b5),
    .PC(b_PC), .PC_plus4(b_PC_plus4), .instret(b_instret), .fault(b_fault)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    reset      = 1'b1;
    stall      = 1'b1;
    PC_select  = 1'b0;
    PC_target  = 32'h0;
    imem_valid = 1'b0;
    imem_rdata = 32'h0;
    b_reset      = 1'b1;
    b_stall      = 1'b1;
    b_PC_select  = 1'b0;
    b_PC_target  = 32'h0;
    b_imem_valid = 1'b0;
    b_imem_rdata = 32'h0;

    step();
    step();
    // Reset state
    check("rst_req",    {31'd0, imem_req},    32'd0);
    check("rst_pc",     PC,                   32'h0);
    check("rst_instr",  instr,                32'h0000_0013);
    check("rst_ivalid", {31'd0, instr_valid}, 32'd0);
    check("rst_instret", instret,             32'd0);
    check("rst_fault",  {31'd0, fault},       32'd0);
    check("rst_opcode", {25'd0, opcode},      32'h13);

    // Test 1: zero-wait fetch and retire
    reset = 1'b0;
    step();                        // IDLE -> FETCH
    check("t1_req",  {31'd0, imem_req}, 32'd1);
    check("t1_addr", imem_addr,         32'h0);
    imem_valid = 1'b1;
    imem_rdata = 32'h0050_0093;
    step();                        // FETCH -> READY
    imem_valid = 1'b0;
    check("t1_ivalid", {31'd0, instr_valid}, 32'd1);
    check("t1_instr",  instr,                32'h0050_0093);
    check("t1_opcode", {25'd0, opcode},      32'h13);
    check("t1_funct3", {29'd0, funct3},      32'd0);
    check("t1_req_lo", {31'd0, imem_req},    32'd0);
    stall = 1'b0;
    step();                        // retire
    stall = 1'b1;
    check("t1_pc",      PC,                   32'h4);
    check("t1_instret", instret,              32'd1);
    check("t1_pcp4",    PC_plus4,             32'h8);
    check("t1_req2",    {31'd0, imem_req},    32'd1);
    check("t1_ivalid0", {31'd0, instr_valid}, 32'd0);

    // Test 2: 3-cycle wait, then a stray valid in READY
    for (int i = 0; i < 3; i++) begin
      check("t2_req_hold",  {31'd0, imem_req},    32'd1);
      check("t2_addr_hold", imem_addr,            32'h4);
      check("t2_ivalid_lo", {31'd0, instr_valid}, 32'd0);
      step();
    end
    imem_valid = 1'b1;
    imem_rdata = 32'h4020_8133;
    step();
    imem_valid = 1'b0;
    check("t2_ivalid", {31'd0, instr_valid}, 32'd1);
    check("t2_instr",  instr,                32'h4020_8133);
    check("t2_opcode", {25'd0, opcode},      32'h33);
    check("t2_f7b5",   {31'd0, funct7b5},    32'd1);
    imem_valid = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    step();
    imem_valid = 1'b0;
    check("t2_stray_instr", instr,             32'h4020_8133);
    check("t2_stray_req",   {31'd0, imem_req}, 32'd0);

    // Test 3: jump held off by stall
    PC_select = 1'b1;
    PC_target = 32'h100;
    for (int i = 0; i < 4; i++) begin
      step();
      check("t3_pc_hold",  PC,                   32'h4);
      check("t3_iv_hold",  {31'd0, instr_valid}, 32'd1);
    end
    stall = 1'b0;
    step();
    stall     = 1'b1;
    PC_select = 1'b0;
    check("t3_addr",    imem_addr,         32'h100);
    check("t3_req",     {31'd0, imem_req}, 32'd1);
    check("t3_instret", instret,           32'd2);
    imem_valid = 1'b1;
    imem_rdata = 32'h0000_0013;
    step();
    imem_valid = 1'b0;
    check("t3_ready", {31'd0, instr_valid}, 32'd1);

    // Test 4: misaligned jump target
    PC_select = 1'b1;
    PC_target = 32'h102;
    stall     = 1'b0;
    step();
    check("t4_fault",   {31'd0, fault},       32'd1);
    check("t4_pc",      PC,                   32'h100);
    check("t4_instret", instret,              32'd2);
    check("t4_ivalid",  {31'd0, instr_valid}, 32'd0);
    PC_select  = 1'b0;
    imem_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("t4_no_req",    {31'd0, imem_req}, 32'd0);
      check("t4_pc_frozen", PC,                32'h100);
      check("t4_sticky",    {31'd0, fault},    32'd1);
    end
    imem_valid = 1'b0;
    stall      = 1'b1;

    // Test 6: async reset while fetching
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("t6_fault_clr", {31'd0, fault}, 32'd0);
    step();                        // FETCH at 0
    imem_valid = 1'b1;
    imem_rdata = 32'h0050_0093;
    step();
    imem_valid = 1'b0;
    stall      = 1'b0;
    step();                        // retire, FETCH at 4
    stall = 1'b1;
    check("t6_pre_req",   {31'd0, imem_req}, 32'd1);
    check("t6_pre_pc",    PC,                32'h4);
    check("t6_pre_instr", instr,             32'h0050_0093);
    #2;
    reset = 1'b1;
    #1;
    check("t6_req_drop",  {31'd0, imem_req}, 32'd0);
    check("t6_pc",        PC,                32'h0);
    check("t6_instr",     instr,             32'h0000_0013);
    check("t6_instret",   instret,           32'd0);
    step();

    // Test 5: PC and instret wrap on sequential retire
    check("t5_rst_instret", b_instret, 32'hFFFF_FFFF);
    check("t5_rst_pcp4",    b_PC_plus4, 32'h0);
    b_reset = 1'b0;
    step();
    check("t5_addr", b_imem_addr,         32'hFFFF_FFFC);
    check("t5_req",  {31'd0, b_imem_req}, 32'd1);
    b_imem_valid = 1'b1;
    b_imem_rdata = 32'h0000_0013;
    step();
    b_imem_valid = 1'b0;
    b_stall      = 1'b0;
    step();
    b_stall = 1'b1;
    check("t5_pc",      b_PC,                32'h0);
    check("t5_instret", b_instret,           32'h0);
    check("t5_fault",   {31'd0, b_fault},    32'd0);
    check("t5_req2",    {31'd0, b_imem_req}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
